// File: rtl/spi_tx_sched_pkg.sv
// Shared definitions for the serial transmit scheduler and its serializer:
// FSM encoding, default frame geometry and a constant-width helper.
package spi_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_CLK_DIV = 4;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the
// pointer, wrapping modulo NREQ.
module rr_arbiter
    import spi_tx_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]        req_i,
    input  logic [clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic [clog2(NREQ)-1:0] idx_o,
    output logic                   any_o
);

    localparam int unsigned IDX_W = clog2(NREQ);

    logic [IDX_W-1:0] k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            k = IDX_W'((32'(ptr_i) + off) % NREQ);
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

endmodule

// File: rtl/spi_tx_sched.sv
// Round-robin scheduler sharing one serial transmit lane between NREQ
// word sources; emits sck/dataout/vld frames MSB first with an idle gap.
module spi_tx_sched
    import spi_tx_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned GAP     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     sck,
    output logic                     dataout,
    output logic                     vld,
    output logic                     busy,
    output logic [clog2(NREQ)-1:0]   owner
);

    localparam int unsigned IDX_W   = clog2(NREQ);
    localparam int unsigned BIT_W   = clog2(DATA_W + 1);
    localparam int unsigned GAP_CYC = GAP * 2 * CLK_DIV;
    localparam int unsigned CNT_MAX = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
    localparam int unsigned CNT_W   = clog2(CNT_MAX + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    own_q, own_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                sck_q, sck_d;
    logic                vld_q, vld_d;
    logic                busy_q, busy_d;
    logic                dout_q, dout_d;

    logic [NREQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [DATA_W-1:0]   sel_word;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_word = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        gnt_d   = '0;
        sck_d   = sck_q;
        vld_d   = vld_q;
        busy_d  = busy_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    state_d = ST_SHIFT;
                    gnt_d   = arb_gnt;
                    sh_d    = sel_word;
                    own_d   = arb_idx;
                    ptr_d   = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    vld_d   = 1'b1;
                    busy_d  = 1'b1;
                    dout_d  = sel_word[DATA_W-1];
                    sck_d   = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        bit_d = bit_q + 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        // Falling edge after the last rising edge closes the frame.
                        if (bit_q == BIT_W'(DATA_W)) begin
                            vld_d  = 1'b0;
                            dout_d = 1'b0;
                            bit_d  = '0;
                            if (GAP > 0) begin
                                state_d = ST_GAP;
                            end else begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            sh_d   = sh_q << 1;
                            dout_d = sh_q[DATA_W-2];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ptr_q   <= '0;
            own_q   <= '0;
            gnt_q   <= '0;
            sck_q   <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            gnt_q   <= gnt_d;
            sck_q   <= sck_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            dout_q  <= dout_d;
        end
    end

    assign gnt     = gnt_q;
    assign sck     = sck_q;
    assign dataout = dout_q;
    assign vld     = vld_q;
    assign busy    = busy_q;
    assign owner   = own_q;

endmodule
